// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequences the PC, issues word reads to a 1-cycle instruction
// memory and queues returned {instr, pc} pairs (2 entries) toward decode, with redirect/flush.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    input  logic        id_ready,
    output logic        misalign_err,
    output logic [1:0]  o_dbg_state
);

    localparam logic [2:0] W_DEPTH = 3'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic        r_inflight;
    logic [63:0] r_inflight_pc;
    logic [31:0] r_q_instr [2];
    logic [63:0] r_q_pc    [2];
    logic [1:0]  r_count;
    logic        r_misalign;

    logic        w_req;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_occupancy;

    // Occupancy counts queued entries plus the outstanding read, ignoring any same-cycle pop,
    // so a response always finds a free slot.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};

    // Decode handshake: a transfer happens on any cycle where id_valid && id_ready; id_valid
    // never depends on id_ready and, once high, the head stays stable until taken or flushed.
    assign w_pop  = (r_count != 2'd0) && id_ready;
    assign w_push = r_inflight && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_state_nxt = ST_REDIR;
                end else begin
                    w_req = (w_occupancy < W_DEPTH);
                end
            end
            ST_REDIR: begin
                w_state_nxt = redirect_valid ? ST_REDIR : ST_RUN;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 64'h0;
            r_misalign    <= 1'b0;
        end else begin
            r_inflight <= w_req;
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (w_req) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= {redirect_pc[63:2], 2'b00};
            end else if (w_req) begin
                r_pc <= r_pc + 64'd4;
            end
        end
    end

    // Entry 0 is always the head, so the decode outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 2'd0;
            r_q_instr[0] <= 32'h0;
            r_q_instr[1] <= 32'h0;
            r_q_pc[0]    <= 64'h0;
            r_q_pc[1]    <= 64'h0;
        end else if (redirect_valid) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_q_instr[r_count[0]] <= imem_rdata;
                    r_q_pc[r_count[0]]    <= r_inflight_pc;
                    r_count               <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q_instr[0] <= r_q_instr[1];
                    r_q_pc[0]    <= r_q_pc[1];
                    r_count      <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_instr[0] <= imem_rdata;
                        r_q_pc[0]    <= r_inflight_pc;
                    end else begin
                        r_q_instr[0] <= r_q_instr[1];
                        r_q_pc[0]    <= r_q_pc[1];
                        r_q_instr[1] <= imem_rdata;
                        r_q_pc[1]    <= r_inflight_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_req     = w_req;
    assign imem_addr    = w_req ? r_pc : 64'h0;
    assign id_valid     = (r_count != 2'd0);
    assign id_instr     = r_q_instr[0];
    assign id_pc        = r_q_pc[0];
    assign misalign_err = r_misalign;
    assign o_dbg_state  = r_state;

endmodule
